ha_serial_adder_ctrl: RTL and testbench
=======================================

Name: ha_serial_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit unsigned addition using one shared 1-bit half-adder cell (sum = x^y, carry = x&y), time-multiplexed over two phases per bit. It accepts operand pairs over a valid/ready handshake and returns the sum and carry-out over a second valid/ready handshake. It sits between the tile input pins and the output pins.

Parameters:
WIDTH, 8, operand/result width in bits (must be ≥1).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand pair on a/b is valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  sum/cout are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  registered result, A+B mod 2^WIDTH
cout  output  1  registered carry-out of A+B
busy  output  1  high in P0/P1 states

Behaviour:
- Reset is asynchronous while rst=1 and takes effect immediately. State goes to IDLE. sum=0, cout=0, out_valid=0, busy=0, and all internal registers clear (op regs, idx, carry, p, g1). in_ready=1 during reset, because it is decoded from IDLE.
- Exactly one half-adder instance. Its inputs are muxed by state. No other adder or XOR on the operand path.
- States: IDLE, P0, P1, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a→opa and b→opb, clear idx, carry and sum, then go to P0.
  - Otherwise stay in IDLE.
- P0:
  - HA inputs are opa[idx] and opb[idx].
  - Register p<=HA.sum and g1<=HA.carry, then go to P1.
- P1:
  - HA inputs are p and carry.
  - Write sum[idx]<=HA.sum and carry<=g1|HA.carry.
  - If idx==WIDTH-1: set cout<=g1|HA.carry and go to DONE.
  - Otherwise idx<=idx+1 and go to P0.
- DONE:
  - out_valid=1. sum and cout are held stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_valid must not depend combinationally on out_ready.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored and does not queue. a/b changes outside the accept edge have no effect.
- Latency and throughput:
  - Accept edge E0.
  - out_valid rises after edge E0+2·WIDTH.
  - With out_ready held high, IDLE is re-entered at E0+2·WIDTH+1.
  - Minimum period between accepts is 2·WIDTH+2 cycles (18 for WIDTH=8).
- sum bits not yet computed read 0 during P0/P1. The consumer must only sample sum/cout while out_valid=1.
- idx width is clog2(WIDTH), minimum 1 bit. For WIDTH=1: one P0/P1 pair, then DONE.
- Simultaneous events:
  - in_valid together with the DONE→IDLE edge: the operands are not accepted on that edge. Acceptance happens only from IDLE.
  - rst overrides every other input in every state.
- Reset mid-operation (P0/P1/DONE): the computation is abandoned. No out_valid pulse is produced, and the block restarts from IDLE after reset deasserts.
- Tile integration:
  - ui_in drives a/b/in_valid.
  - uo_out carries sum, cout and out_valid.
  - uio_oe is a constant (fixed by the top level).

Test Plan:
- After reset, WIDTH=8, a=0x5A, b=0x3C, in_valid for one cycle, out_ready=1 → out_valid asserts exactly 16 cycles after the accept edge with sum=0x96, cout=0, busy high for 16 cycles.
- a=0xFF, b=0x01 → sum=0x00, cout=1. Also a=0xFF, b=0xFF → sum=0xFE, cout=1. Also a=0, b=0 → sum=0, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum, cout and out_valid are stable, in_ready=0 throughout. Raising out_ready gives IDLE on the next edge.
- Busy rejection: assert in_valid with a=0x11, b=0x22 during P0/P1 of a 0x01+0x02 operation → result is 0x03. The second pair is not processed unless it is still presented in IDLE.
- Reset mid-operation: assert rst asynchronously (between clock edges) at bit 4 of 0xF0+0x0F → outputs immediately go to 0 and state to IDLE. A new 0x80+0x80 then gives sum=0x00, cout=1.
- Back-to-back: in_valid and out_ready tied high, 4 operand pairs → accepts are spaced exactly 18 cycles apart, and every result matches a reference model.

Source files
------------

// File: rtl/ha_serial_adder_ctrl_if.sv
// ha_serial_adder_ctrl_if: operand-in / result-out handshake bundle for the serial adder
interface ha_serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum, cout, busy);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/ha_serial_adder_ctrl.sv
// ha_serial_adder_ctrl: WIDTH-bit adder built from one half-adder cell reused over two phases per bit
module ha_serial_adder_ctrl_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module ha_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ha_serial_adder_ctrl_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, P0, P1, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, p_q, p_d, g1_q, g1_d, cout_q, cout_d;
  logic             ha_x, ha_y, ha_s, ha_c;
  ha_serial_adder_ctrl_ha u_ha (.x_i(ha_x), .y_i(ha_y), .s_o(ha_s), .c_o(ha_c));
  // P0 adds the operand bits, P1 folds in the running carry
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    p_d     = p_q;
    g1_d    = g1_q;
    cout_d  = cout_q;
    ha_x    = (state_q == P0) ? opa_q[idx_q] : p_q;
    ha_y    = (state_q == P0) ? opb_q[idx_q] : carry_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        opa_d   = bus.a;
        opb_d   = bus.b;
        idx_d   = '0;
        carry_d = 1'b0;
        sum_d   = '0;
        state_d = P0;
      end
      P0: begin
        p_d     = ha_s;
        g1_d    = ha_c;
        state_d = P1;
      end
      P1: begin
        sum_d[idx_q] = ha_s;
        carry_d      = g1_q | ha_c;
        if (idx_q == LAST) begin
          cout_d  = g1_q | ha_c;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = P0;
        end
      end
      default: state_d = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      p_q     <= 1'b0;
      g1_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      g1_q    <= g1_d;
      cout_q  <= cout_d;
    end
  end
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == P0) || (state_q == P1);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_ha_serial_adder_ctrl.sv
// tb_ha_serial_adder_ctrl: vector table, handshake scoreboard and corner-case sequences
module tb_ha_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [8:0] sb[$];
  int acc[$];
  ha_serial_adder_ctrl_if #(.WIDTH(8)) bus ();
  ha_serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [7:0] a; logic [7:0] b; logic [7:0] s; logic c;} vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  // Handshakes are seen at the negedge before the edge that completes them
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({1'b0, bus.a} + {1'b0, bus.b});
        acc.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected none", {bus.cout, bus.sum});
        end else chk("sb_result", {23'd0, bus.cout, bus.sum}, {23'd0, sb.pop_front()});
      end
    end
  end
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                        input logic ec, input bit bp);
    int lat, bcnt, k;
    k = 0;
    while (!bus.in_ready && k < 50) begin step(); k++; end
    bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = !bp;
    step();
    bus.in_valid = 1'b0;
    bcnt = int'(bus.busy);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
      bcnt += int'(bus.busy);
    end
    chk("latency", 32'(lat), 32'd16);
    chk("busy_cycles", 32'(bcnt), 32'd16);
    chk("sum", {24'd0, bus.sum}, {24'd0, es});
    chk("cout", {31'd0, bus.cout}, {31'd0, ec});
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        step();
        chk("bp_hold", {21'd0, bus.out_valid, bus.in_ready, bus.cout, bus.sum},
            {21'd0, 1'b1, 1'b0, ec, es});
      end
      bus.out_ready = 1'b1;
    end
    step();
    chk("idle_after_done", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask
  initial begin
    int k;
    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[5] = '{8'h01, 8'hFF, 8'h00, 1'b1};
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    #1;
    chk("reset_outputs", {20'd0, bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum},
        {20'd0, 12'h800});
    step();
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 1'b0);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b1);
    // Operands offered while busy must be ignored
    bus.a = 8'h01; bus.b = 8'h02; bus.in_valid = 1'b1;
    step();
    bus.a = 8'h11; bus.b = 8'h22;
    repeat (6) step();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 100) begin step(); k++; end
    chk("busy_reject_sum", {23'd0, bus.cout, bus.sum}, 32'h003);
    step();
    repeat (3) begin
      step();
      chk("busy_reject_no_accept", {31'd0, bus.in_ready}, 32'd1);
    end
    // Asynchronous reset in the middle of bit 4
    bus.a = 8'hF0; bus.b = 8'h0F; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (8) step();
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset", {20'd0, bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum},
        {20'd0, 12'h800});
    step();
    rst = 1'b0;
    step();
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    // Back-to-back: four accepts with in_valid and out_ready held high
    acc.delete();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a = 8'($urandom_range(0, 255));
      bus.b = 8'($urandom_range(0, 255));
      step();
      if (i == 3) bus.in_valid = 1'b0;
      k = 0;
      while (!bus.in_ready && k < 100) begin step(); k++; end
    end
    repeat (3) step();
    chk("b2b_accepts", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd18);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
